// File: rtl/bingo_pkg.sv
// Shared constants, line masks and FSM encoding for the bingo marking engine.
package bingo_pkg;

    localparam int CELLS     = 25;
    localparam int NUM_W     = 5;
    localparam int LINES     = 12;
    localparam int WIN_LINES = 5;
    localparam int IDX_W     = 5;
    localparam int CNT_W     = 4;

    localparam logic [IDX_W-1:0] SCAN_LAST  = 5'd24;
    localparam logic [IDX_W-1:0] LINES_LAST = 5'd11;

    // Rows 0-4, columns 0-4, main diagonal, anti-diagonal.
    localparam logic [CELLS-1:0] LINE_MASKS [LINES] = '{
        25'h000001F, 25'h00003E0, 25'h0007C00, 25'h00F8000, 25'h1F00000,
        25'h0108421, 25'h0210842, 25'h0421084, 25'h0842108, 25'h1084210,
        25'h1041041, 25'h0111110
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_LINES = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bin_to_bcd8.sv
// Combinational NUM_W-bit binary to two-digit BCD {tens, ones}; range 0..31.
module bin_to_bcd8
    import bingo_pkg::*;
(
    input  logic [NUM_W-1:0] bin,
    output logic [7:0]       bcd
);

    logic [3:0] tens_s;
    logic [3:0] ones_s;

    // Subtract the largest multiple of ten not exceeding the input.
    always_comb begin
        tens_s = 4'd0;
        ones_s = 4'd0;
        if (bin >= 5'd30) begin
            tens_s = 4'd3;
            ones_s = 4'(bin - 5'd30);
        end else if (bin >= 5'd20) begin
            tens_s = 4'd2;
            ones_s = 4'(bin - 5'd20);
        end else if (bin >= 5'd10) begin
            tens_s = 4'd1;
            ones_s = 4'(bin - 5'd10);
        end else begin
            tens_s = 4'd0;
            ones_s = 4'(bin);
        end
    end

    assign bcd = {tens_s, ones_s};

endmodule

// File: rtl/bingo_mark_engine.sv
// Marks cells matching a called number one cell per cycle, then re-evaluates
// the twelve bingo lines one per cycle; fixed 38-cycle call latency.
module bingo_mark_engine
    import bingo_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   interboard_rst,
    input  logic [CELLS*NUM_W-1:0] map,
    input  logic                   call_valid,
    input  logic [NUM_W-1:0]       call_num,
    output logic                   call_ready,
    output logic [CELLS-1:0]       circle,
    output logic [LINES-1:0]       line,
    output logic [CNT_W-1:0]       line_count,
    output logic [7:0]             display_nums,
    output logic                   done,
    output logic                   found,
    output logic                   win
);

    state_t                 state_r;
    logic [IDX_W-1:0]       idx_r;
    logic [CELLS*NUM_W-1:0] map_r;
    logic [NUM_W-1:0]       num_r;
    logic [CELLS-1:0]       circle_r;
    logic [LINES-1:0]       line_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [7:0]             disp_r;
    logic                   done_r;
    logic                   found_r;
    logic                   acc_r;
    logic                   win_r;
    logic                   ready_r;

    logic [NUM_W-1:0]       cell_s;
    logic                   hit_s;
    logic [LINES-1:0]       line_next_s;
    logic [CNT_W-1:0]       pop_s;
    logic [7:0]             bcd_s;

    bin_to_bcd8 u_bcd (
        .bin (call_num),
        .bcd (bcd_s)
    );

    // Cell compare for SCAN, next line vector and its popcount for LINES.
    always_comb begin
        cell_s      = map_r[NUM_W*int'(idx_r) +: NUM_W];
        hit_s       = (cell_s == num_r) && (num_r != 5'd0);
        line_next_s = line_r;
        pop_s       = 4'd0;
        if ((state_r == ST_LINES) && (idx_r <= LINES_LAST)) begin
            line_next_s[idx_r[3:0]] = line_r[idx_r[3:0]] |
                (&(circle_r | ~LINE_MASKS[idx_r[3:0]]));
        end else begin
            line_next_s = line_r;
        end
        for (int i = 0; i < LINES; i++) begin
            pop_s = pop_s + {3'd0, line_next_s[i]};
        end
    end

    // Main sequencer; done/found/line_count/win are produced on the edge
    // that enters DONE so they are visible throughout the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst || interboard_rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= 5'd0;
            map_r    <= '0;
            num_r    <= 5'd0;
            circle_r <= 25'd0;
            line_r   <= 12'd0;
            cnt_r    <= 4'd0;
            disp_r   <= 8'h00;
            done_r   <= 1'b0;
            found_r  <= 1'b0;
            acc_r    <= 1'b0;
            win_r    <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (call_valid && ready_r) begin
                        map_r   <= map;
                        num_r   <= call_num;
                        disp_r  <= bcd_s;
                        found_r <= 1'b0;
                        acc_r   <= 1'b0;
                        idx_r   <= 5'd0;
                        ready_r <= 1'b0;
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit_s) begin
                        circle_r[idx_r] <= 1'b1;
                        if (!circle_r[idx_r]) begin
                            acc_r <= 1'b1;
                        end
                    end
                    if (idx_r == SCAN_LAST) begin
                        idx_r   <= 5'd0;
                        state_r <= ST_LINES;
                    end else begin
                        idx_r <= idx_r + 5'd1;
                    end
                end
                ST_LINES: begin
                    line_r <= line_next_s;
                    if (idx_r == LINES_LAST) begin
                        idx_r   <= 5'd0;
                        done_r  <= 1'b1;
                        found_r <= acc_r;
                        cnt_r   <= pop_s;
                        if (pop_s >= 4'(WIN_LINES)) begin
                            win_r <= 1'b1;
                        end
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + 5'd1;
                    end
                end
                ST_DONE: begin
                    ready_r <= !win_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign call_ready   = ready_r;
    assign circle       = circle_r;
    assign line         = line_r;
    assign line_count   = cnt_r;
    assign display_nums = disp_r;
    assign done         = done_r;
    assign found        = found_r;
    assign win          = win_r;

endmodule

// File: tb/tb_bingo_mark_engine.sv
// Directed, table-driven bench for bingo_mark_engine with hand-written
// sequences for latency, mid-call reset and win lockout.
module tb_bingo_mark_engine;
    import bingo_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   interboard_rst = 1'b0;
    logic [CELLS*NUM_W-1:0] map = '0;
    logic                   call_valid = 1'b0;
    logic [NUM_W-1:0]       call_num = 5'd0;
    logic                   call_ready;
    logic [CELLS-1:0]       circle;
    logic [LINES-1:0]       line;
    logic [CNT_W-1:0]       line_count;
    logic [7:0]             display_nums;
    logic                   done;
    logic                   found;
    logic                   win;

    int n_cmp = 0;
    int n_bad = 0;

    bingo_mark_engine dut (
        .clk            (clk),
        .rst            (rst),
        .interboard_rst (interboard_rst),
        .map            (map),
        .call_valid     (call_valid),
        .call_num       (call_num),
        .call_ready     (call_ready),
        .circle         (circle),
        .line           (line),
        .line_count     (line_count),
        .display_nums   (display_nums),
        .done           (done),
        .found          (found),
        .win            (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [4:0]  num;
        logic        ef;
        logic [24:0] ec;
        logic [11:0] el;
        logic [3:0]  en;
        logic [7:0]  ed;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [CELLS*NUM_W-1:0] identity_map();
        logic [CELLS*NUM_W-1:0] m;
        m = '0;
        for (int i = 0; i < CELLS; i++) m[5*i +: 5] = 5'(i + 1);
        return m;
    endfunction

    task automatic do_reset(input bit use_peer);
        @(negedge clk);
        if (use_peer) interboard_rst = 1'b1; else rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        interboard_rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".circle"}, circle, 0);
        chk({tag, ".line"}, line, 0);
        chk({tag, ".cnt"}, line_count, 0);
        chk({tag, ".disp"}, display_nums, 0);
        chk({tag, ".flags"}, {done, found, win}, 0);
        chk({tag, ".ready"}, call_ready, 1);
    endtask

    // Accept a call at the next rising edge; returns right after that edge.
    task automatic start_call(input logic [4:0] num);
        @(negedge clk);
        call_valid = 1'b1;
        call_num   = num;
        @(posedge clk);
        #1;
        call_valid = 1'b0;
    endtask

    task automatic run_call(input string tag, input logic [4:0] num, input logic ef,
                            input logic [24:0] ec, input logic [11:0] el,
                            input logic [3:0] en, input logic [7:0] ed, input logic ew);
        int n;
        @(negedge clk);
        chk({tag, ".ready"}, call_ready, 1);
        start_call(num);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
        chk({tag, ".latency"}, n, 38);
        chk({tag, ".found"}, found, ef);
        chk({tag, ".circle"}, circle, ec);
        chk({tag, ".line"}, line, el);
        chk({tag, ".cnt"}, line_count, en);
        chk({tag, ".disp"}, display_nums, ed);
        chk({tag, ".win"}, win, ew);
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int bad_ready;
        int bad_done;
        int pulses;
        logic [24:0] circ;

        vecs[0]  = '{1'b1, 5'd1,  1'b1, 25'h0000001, 12'h000, 4'd0, 8'h01};
        vecs[1]  = '{1'b0, 5'd2,  1'b1, 25'h0000003, 12'h000, 4'd0, 8'h02};
        vecs[2]  = '{1'b0, 5'd3,  1'b1, 25'h0000007, 12'h000, 4'd0, 8'h03};
        vecs[3]  = '{1'b0, 5'd4,  1'b1, 25'h000000F, 12'h000, 4'd0, 8'h04};
        vecs[4]  = '{1'b0, 5'd5,  1'b1, 25'h000001F, 12'h001, 4'd1, 8'h05};
        vecs[5]  = '{1'b1, 5'd1,  1'b1, 25'h0000001, 12'h000, 4'd0, 8'h01};
        vecs[6]  = '{1'b0, 5'd7,  1'b1, 25'h0000041, 12'h000, 4'd0, 8'h07};
        vecs[7]  = '{1'b0, 5'd13, 1'b1, 25'h0001041, 12'h000, 4'd0, 8'h13};
        vecs[8]  = '{1'b0, 5'd19, 1'b1, 25'h0041041, 12'h000, 4'd0, 8'h19};
        vecs[9]  = '{1'b0, 5'd25, 1'b1, 25'h1041041, 12'h400, 4'd1, 8'h25};
        vecs[10] = '{1'b0, 5'd5,  1'b1, 25'h1041051, 12'h400, 4'd1, 8'h05};
        vecs[11] = '{1'b0, 5'd9,  1'b1, 25'h1041151, 12'h400, 4'd1, 8'h09};
        vecs[12] = '{1'b0, 5'd17, 1'b1, 25'h1051151, 12'h400, 4'd1, 8'h17};
        vecs[13] = '{1'b0, 5'd21, 1'b1, 25'h1151151, 12'hC00, 4'd2, 8'h21};
        vecs[14] = '{1'b0, 5'd7,  1'b0, 25'h1151151, 12'hC00, 4'd2, 8'h07};
        vecs[15] = '{1'b0, 5'd0,  1'b0, 25'h1151151, 12'hC00, 4'd2, 8'h00};
        vecs[16] = '{1'b0, 5'd30, 1'b0, 25'h1151151, 12'hC00, 4'd2, 8'h30};

        map = identity_map();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset0");

        // Exact latency and ready-low window for a single call.
        bad_ready = 0;
        bad_done  = 0;
        start_call(5'd13);
        map = '0;
        for (int k = 1; k <= 38; k++) begin
            @(negedge clk);
            if (call_ready !== 1'b0) bad_ready++;
            if (k < 38 && done !== 1'b0) bad_done++;
            if (k == 38) chk("timing.done38", done, 1);
        end
        chk("timing.ready_low", bad_ready, 0);
        chk("timing.early_done", bad_done, 0);
        chk("timing.circle", circle, 25'h0001000);
        chk("timing.disp", display_nums, 8'h13);
        chk("timing.found", found, 1);
        @(negedge clk);
        chk("timing.done_pulse", done, 0);
        chk("timing.ready_after", call_ready, 1);
        map = identity_map();

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst_before) do_reset(1'b0);
            run_call($sformatf("vec%0d", i), vecs[i].num, vecs[i].ef, vecs[i].ec,
                     vecs[i].el, vecs[i].en, vecs[i].ed, 1'b0);
        end

        // Duplicate numbers: every column-0 cell holds 1.
        do_reset(1'b1);
        for (int i = 0; i < CELLS; i++) map[5*i +: 5] = 5'((i % 5) + 1);
        run_call("dup1", 5'd1, 1'b1, 25'h0108421, 12'h020, 4'd1, 8'h01, 1'b0);
        run_call("oor27", 5'd27, 1'b0, 25'h0108421, 12'h020, 4'd1, 8'h27, 1'b0);

        // rst during SCAN (idx 10) drops the call.
        map = identity_map();
        do_reset(1'b0);
        run_call("pre1", 5'd1, 1'b1, 25'h0000001, 12'h000, 4'd0, 8'h01, 1'b0);
        start_call(5'd2);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_state("scan_rst");
        count_done(45, pulses);
        chk("scan_rst.no_done", pulses, 0);
        run_call("post3", 5'd3, 1'b1, 25'h0000004, 12'h000, 4'd0, 8'h03, 1'b0);

        // interboard_rst during LINES drops the call.
        start_call(5'd4);
        repeat (30) @(negedge clk);
        interboard_rst = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        chk_reset_state("lines_rst");
        count_done(45, pulses);
        chk("lines_rst.no_done", pulses, 0);
        run_call("post6", 5'd6, 1'b1, 25'h0000020, 12'h000, 4'd0, 8'h06, 1'b0);

        // Rows 0-3 then cell 22 (column 2) reach five lines and win.
        do_reset(1'b0);
        for (int k = 1; k <= 20; k++) begin
            circ = 25'((32'd1 << k) - 32'd1);
            run_call($sformatf("row%0d", k), 5'(k), 1'b1, circ,
                     12'((16'd1 << (k / 5)) - 16'd1), 4'(k / 5), bcd(k), 1'b0);
        end
        run_call("win23", 5'd23, 1'b1, 25'h04FFFFF, 12'h08F, 4'd5, 8'h23, 1'b1);
        @(negedge clk);
        chk("win.ready", call_ready, 0);
        call_valid = 1'b1;
        call_num   = 5'd24;
        count_done(50, pulses);
        call_valid = 1'b0;
        chk("win.no_done", pulses, 0);
        chk("win.hold_circle", circle, 25'h04FFFFF);
        chk("win.hold_disp", display_nums, 8'h23);
        chk("win.hold_flags", {call_ready, win, line_count}, {1'b0, 1'b1, 4'd5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
